singbuf_job_sched: RTL and testbench

- Job scheduler in front of one single-buffer (SINGBUF-class) instance.
- Queues host-issued buffer configurations (nPeriod, nData), applies them one at a time, pulses start, and tracks read handshakes to detect job completion.
- Holds buffer config stable for the whole job, reports done/error, and aborts a job by resetting the buffer.
- Sits between the host/control plane and the buffer. The data path (data_in/data_out/we) does not pass through this block.

---
 rtl/singbuf_sched_pkg.sv | 25 ++
 rtl/sched_job_fifo.sv | 54 +++++
 rtl/singbuf_job_sched.sv | 183 ++++++++++++++++++
 tb/tb_singbuf_job_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/singbuf_sched_pkg.sv
// Shared types for the single-buffer job scheduler: config field widths,
// the packed job descriptor and the scheduler state encoding.
package singbuf_sched_pkg;

   localparam int unsigned MAX_NDATA_DEF   = 1024;
   localparam int unsigned MAX_NPERIOD_DEF = 524288;
   localparam int unsigned NDATA_W         = $clog2(MAX_NDATA_DEF);
   localparam int unsigned NPER_W          = $clog2(MAX_NPERIOD_DEF);

   typedef struct packed {
      logic [NPER_W-1:0]  n_period;
      logic [NDATA_W-1:0] n_data;
   } job_cfg_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      LOAD,
      START,
      RUN,
      DONE,
      ABORT
   } state_t;

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued job configs;
// the head word is visible on rd_data whenever empty is low.
module sched_job_fifo #(
   parameter int unsigned WIDTH = 29,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/singbuf_job_sched.sv
// Job scheduler in front of one single-buffer instance: queues {nPeriod, nData}
// jobs, runs them one at a time and watches read beats for completion.
// Optional RUN watchdog enabled by defining SINGBUF_SCHED_TIMEOUT_EN.
module singbuf_job_sched
   import singbuf_sched_pkg::*;
#(
   parameter int unsigned MAX_NDATA   = 1024,
   parameter int unsigned MAX_NPERIOD = 524288,
   parameter int unsigned JOB_DEPTH   = 4,
   parameter int unsigned CNT_W       = 16
`ifdef SINGBUF_SCHED_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT     = 4096
`endif
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [$clog2(MAX_NPERIOD)+$clog2(MAX_NDATA)-1:0] job_cfg,
   input  logic                                            job_valid,
   output logic                                            job_ready,
   input  logic                                            abort,
   output logic [$clog2(MAX_NPERIOD)+$clog2(MAX_NDATA)-1:0] buf_cfg,
   output logic                                            buf_start,
   output logic                                            buf_rst_n,
   input  logic                                            buf_re,
   input  logic                                            buf_rrdy,
   output logic                                            busy,
   output logic                                            job_done,
   output logic                                            job_err,
   output logic [CNT_W-1:0]                                jobs_completed,
`ifdef SINGBUF_SCHED_TIMEOUT_EN
   output logic                                            timeout_flag,
`endif
   output logic [$clog2(JOB_DEPTH):0]                      q_level
);

   localparam int unsigned DW = $clog2(MAX_NDATA);
   localparam int unsigned PW = $clog2(MAX_NPERIOD);
   localparam int unsigned CW = DW + PW;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cfg_q;
   logic [CW-1:0]   buf_cfg_q;
   logic [CW-1:0]   fifo_head;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic [DW-1:0]   n_data;
   logic [PW-1:0]   n_period;
   logic [DW-1:0]   d_cnt;
   logic [PW-1:0]   p_cnt;
   logic            cfg_bad;
   logic            re_hs;
   logic            d_last;
   logic            p_last;
   logic            ab_cnt;

   assign job_ready = !fifo_full;
   assign push      = job_valid && job_ready;
   assign pop       = (state == IDLE) && !fifo_empty;

   sched_job_fifo #(
      .WIDTH (CW),
      .DEPTH (JOB_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (job_cfg),
      .pop     (pop),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (q_level)
   );

   assign n_data   = cfg_q[DW-1:0];
   assign n_period = cfg_q[CW-1:DW];
   assign cfg_bad  = (n_data == '0) || (n_period == '0);
   assign re_hs    = buf_re && buf_rrdy;
   assign d_last   = (d_cnt == n_data - DW'(1));
   assign p_last   = (p_cnt == n_period - PW'(1));

`ifdef SINGBUF_SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT);

   logic [TW-1:0] wd_cnt;
   logic          wd_hit;
   logic          tmo_q;

   // Fires on the cycle the counter would step onto TIMEOUT-1.
   assign wd_hit = (state == RUN) && !re_hs && (wd_cnt == TW'(TIMEOUT - 2));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         tmo_q  <= 1'b0;
      end else begin
         if ((state != RUN) || re_hs) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + TW'(1);
         end
         if (state != ABORT) begin
            tmo_q <= wd_hit && !abort;
         end
      end
   end

   assign timeout_flag = (state == ABORT) && !ab_cnt && tmo_q;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (!fifo_empty) state_nx = CHECK;
         CHECK: state_nx = cfg_bad ? IDLE : LOAD;
         LOAD:  state_nx = abort ? ABORT : START;
         START: state_nx = abort ? ABORT : RUN;
         RUN: begin
            if (abort) begin
               state_nx = ABORT;
            end else if (re_hs && d_last && p_last) begin
               state_nx = DONE;
            end
`ifdef SINGBUF_SCHED_TIMEOUT_EN
            else if (wd_hit) begin
               state_nx = ABORT;
            end
`endif
         end
         DONE:    state_nx = IDLE;
         ABORT:   if (ab_cnt) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign buf_cfg   = buf_cfg_q;
   assign buf_start = (state == START);
   assign job_done  = (state == DONE);
   assign job_err   = ((state == CHECK) && cfg_bad) || ((state == ABORT) && !ab_cnt);
   assign busy      = (state == LOAD) || (state == START) || (state == RUN) || (state == ABORT);
   assign buf_rst_n = !(rst || (state == ABORT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cfg_q          <= '0;
         buf_cfg_q      <= '0;
         d_cnt          <= '0;
         p_cnt          <= '0;
         ab_cnt         <= 1'b0;
         jobs_completed <= '0;
      end else begin
         state <= state_nx;
         if (pop) begin
            cfg_q <= fifo_head;
         end
         // buf_cfg only moves on an accepted job, so rejects never disturb the buffer.
         if ((state == CHECK) && !cfg_bad) begin
            buf_cfg_q <= cfg_q;
         end
         if (state == START) begin
            d_cnt <= '0;
            p_cnt <= '0;
         end else if ((state == RUN) && re_hs) begin
            if (d_last) begin
               d_cnt <= '0;
               p_cnt <= p_cnt + PW'(1);
            end else begin
               d_cnt <= d_cnt + DW'(1);
            end
         end
         ab_cnt <= (state == ABORT) && !ab_cnt;
         if ((state == DONE) && (jobs_completed != '1)) begin
            jobs_completed <= jobs_completed + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_singbuf_job_sched.sv
// Scoreboard bench for singbuf_job_sched: stimulus queues expected start/done/err
// events, a negedge monitor pops and checks them as the DUT produces them.
`timescale 1ns/1ps
module tb_singbuf_job_sched;

   localparam int unsigned DW = 10;
   localparam int unsigned PW = 19;
   localparam int unsigned CW = DW + PW;

   localparam int OUT_DONE  = 0;
   localparam int OUT_ERR   = 1;
   localparam int OUT_ABORT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] job_cfg;
   logic          job_valid;
   logic          job_ready;
   logic          abort;
   logic [CW-1:0] buf_cfg;
   logic          buf_start;
   logic          buf_rst_n;
   logic          buf_re;
   logic          buf_rrdy;
   logic          busy;
   logic          job_done;
   logic          job_err;
   logic [15:0]   jobs_completed;
   logic [2:0]    q_level;
`ifdef SINGBUF_SCHED_TIMEOUT_EN
   logic          timeout_flag;
`endif

   always #5 clk = ~clk;

   singbuf_job_sched #(
      .MAX_NDATA   (1024),
      .MAX_NPERIOD (524288),
      .JOB_DEPTH   (4),
      .CNT_W       (16)
`ifdef SINGBUF_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT     (16)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .job_cfg        (job_cfg),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .abort          (abort),
      .buf_cfg        (buf_cfg),
      .buf_start      (buf_start),
      .buf_rst_n      (buf_rst_n),
      .buf_re         (buf_re),
      .buf_rrdy       (buf_rrdy),
      .busy           (busy),
      .job_done       (job_done),
      .job_err        (job_err),
      .jobs_completed (jobs_completed),
`ifdef SINGBUF_SCHED_TIMEOUT_EN
      .timeout_flag   (timeout_flag),
`endif
      .q_level        (q_level)
   );

   typedef enum int {EV_START, EV_DONE, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t      kind;
      logic [CW-1:0] cfg;
   } ev_t;

   ev_t           sb[$];
   int            n_chk    = 0;
   int            n_fail   = 0;
   int            exp_done = 0;
   logic          mon_en   = 1'b0;
   logic          in_job   = 1'b0;
   logic [CW-1:0] cur_cfg  = '0;

   function automatic logic [CW-1:0] mk(input int unsigned p, input int unsigned d);
      return {PW'(p), DW'(d)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return buf_start;
         1:       return job_done;
         2:       return job_err;
`ifdef SINGBUF_SCHED_TIMEOUT_EN
         3:       return timeout_flag;
`endif
         default: return 1'b0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge where the event is seen; n = negedges waited before it.
   task automatic wait_sig(input int sel, input string name, output int n);
      n = 0;
      @(negedge clk);
      while (!sig(sel) && n < 400) begin
         n++;
         @(negedge clk);
      end
      if (!sig(sel)) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no pulse within %0d cycles, required one", name, n);
      end
   endtask

   // Called just after a posedge; returns just after the posedge that took the job.
   task automatic push(input logic [CW-1:0] cfg, input int outcome);
      int n;
      ev_t e;
      job_valid = 1'b1;
      job_cfg   = cfg;
      n         = 0;
      @(negedge clk);
      while (!job_ready && n < 400) begin
         n++;
         @(negedge clk);
      end
      if (!job_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL push_wait: job_ready got 0, required 1");
      end else begin
         e.cfg = cfg;
         if (outcome != OUT_ERR) begin
            e.kind = EV_START;
            sb.push_back(e);
         end
         e.kind = (outcome == OUT_DONE) ? EV_DONE : EV_ERR;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      job_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      ev_t      e;
      ev_kind_t k;
      if (!mon_en) begin
         in_job = 1'b0;
      end else begin
         if (in_job) chk("cfg_stable", buf_cfg, cur_cfg);
         if (buf_start || job_done || job_err) begin
            k = buf_start ? EV_START : (job_done ? EV_DONE : EV_ERR);
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got event kind %0d, required none", k);
            end else begin
               e = sb.pop_front();
               chk("sb_kind", k, e.kind);
               if (k == EV_START) begin
                  chk("sb_start_cfg", buf_cfg, e.cfg);
                  cur_cfg = e.cfg;
                  in_job  = 1'b1;
               end else if (k == EV_DONE) begin
                  chk("sb_done_count", jobs_completed, exp_done);
                  exp_done++;
                  in_job = 1'b0;
               end else begin
                  in_job = 1'b0;
               end
            end
         end
      end
   end

   initial begin : stim
      int n;
      int prev;
      rst       = 1'b1;
      job_valid = 1'b0;
      job_cfg   = '0;
      abort     = 1'b0;
      buf_re    = 1'b0;
      buf_rrdy  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_buf_rst_n_low", buf_rst_n, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_buf_cfg", buf_cfg, 0);
      chk("rst_buf_start", buf_start, 0);
      chk("rst_buf_rst_n_high", buf_rst_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_job_done", job_done, 0);
      chk("rst_job_err", job_err, 0);
      chk("rst_jobs", jobs_completed, 0);
      chk("rst_q_level", q_level, 0);
      chk("rst_job_ready", job_ready, 1);
      step();
      mon_en = 1'b1;

      // basic job {2,4}, consumer always reading
      buf_re   = 1'b1;
      buf_rrdy = 1'b1;
      push(mk(2, 4), OUT_DONE);
      wait_sig(0, "basic_start", n);
      chk("basic_start_latency", n + 1, 4);
      wait_sig(1, "basic_done", n);
      chk("basic_done_after_8_beats", n, 8);
      @(negedge clk);
      chk("basic_jobs", jobs_completed, 1);

      // queue: stall J0, fill FIFO with four more, fifth held off
      step();
      buf_rrdy = 1'b0;
      push(mk(1, 2), OUT_DONE);
      wait_sig(0, "queue_j0_start", n);
      step();
      push(mk(1, 1), OUT_DONE);
      push(mk(1, 2), OUT_DONE);
      push(mk(2, 1), OUT_DONE);
      push(mk(1, 3), OUT_DONE);
      @(negedge clk);
      chk("queue_level_full", q_level, 4);
      chk("queue_ready_low", job_ready, 0);
      step();
      job_valid = 1'b1;
      job_cfg   = mk(3, 1);
      repeat (4) @(negedge clk);
      chk("queue_held_ready", job_ready, 0);
      chk("queue_held_level", q_level, 4);
      step();
      buf_rrdy = 1'b1;
      push(mk(3, 1), OUT_DONE);
      @(negedge clk);
      chk("queue_refill_level", q_level, 4);
      prev = 4;
      n    = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         if (q_level != prev) begin
            chk("queue_level_step", q_level, prev - 1);
            prev = q_level;
         end
         n++;
      end
      @(negedge clk);
      chk("queue_drained_level", q_level, 0);
      chk("queue_jobs", jobs_completed, 7);
      chk("queue_ready_back", job_ready, 1);

      // reject a zero-period job, then a good one
      step();
      push(mk(0, 8), OUT_ERR);
      wait_sig(2, "reject_err", n);
      chk("reject_err_latency", n, 1);
      @(negedge clk);
      chk("reject_jobs", jobs_completed, 7);
      chk("reject_busy", busy, 0);
      step();
      push(mk(1, 3), OUT_DONE);
      wait_sig(1, "after_reject_done", n);
      chk("after_reject_done_latency", n, 7);

      // abort on the 3rd beat of {1,16}, queued {1,2} then runs
      step();
      push(mk(1, 16), OUT_ABORT);
      push(mk(1, 2), OUT_DONE);
      wait_sig(0, "abort_start", n);
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      step();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_rst_n_c1", buf_rst_n, 0);
      chk("abort_err_c1", job_err, 1);
      chk("abort_busy", busy, 1);
      @(negedge clk);
      chk("abort_rst_n_c2", buf_rst_n, 0);
      chk("abort_err_c2", job_err, 0);
      @(negedge clk);
      chk("abort_rst_n_back", buf_rst_n, 1);
      wait_sig(1, "abort_next_done", n);
      chk("abort_next_done_latency", n, 5);

      // abort coincident with the final beat of {1,2}
      step();
      push(mk(1, 2), OUT_ABORT);
      wait_sig(0, "abort_final_start", n);
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      chk("abort_final_no_done_run", job_done, 0);
      step();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_final_no_done", job_done, 0);
      chk("abort_final_err", job_err, 1);
      chk("abort_final_rst_n", buf_rst_n, 0);
      repeat (2) @(negedge clk);
      chk("abort_final_jobs", jobs_completed, 9);

`ifdef SINGBUF_SCHED_TIMEOUT_EN
      // one beat then stall until the watchdog fires
      step();
      push(mk(1, 4), OUT_ABORT);
      wait_sig(0, "tmo_start", n);
      @(posedge clk);
      step();
      buf_rrdy = 1'b0;
      wait_sig(3, "tmo_flag", n);
      chk("tmo_latency", n + 1, 16);
      chk("tmo_err", job_err, 1);
      chk("tmo_rst_n_c1", buf_rst_n, 0);
      @(negedge clk);
      chk("tmo_rst_n_c2", buf_rst_n, 0);
      chk("tmo_flag_once", timeout_flag, 0);
      @(negedge clk);
      chk("tmo_rst_n_back", buf_rst_n, 1);
      step();
      buf_rrdy = 1'b1;
`endif

      // reset in the middle of a long job with one more queued
      step();
      push(mk(4, 16), OUT_DONE);
      push(mk(1, 1), OUT_DONE);
      wait_sig(0, "midrst_start", n);
      step();
      mon_en = 1'b0;
      rst    = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midrst_rst_n_low", buf_rst_n, 0);
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_q_level", q_level, 0);
      chk("midrst_jobs", jobs_completed, 0);
      chk("midrst_buf_cfg", buf_cfg, 0);
      chk("midrst_rst_n_held", buf_rst_n, 0);
      step();
      rst      = 1'b0;
      exp_done = 0;
      mon_en   = 1'b1;
      push(mk(1, 1), OUT_DONE);
      wait_sig(1, "midrst_after_done", n);
      @(negedge clk);
      chk("midrst_after_jobs", jobs_completed, 1);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
